// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl -- E-stage multiply/divide unit and sequencer.
//
// Owns the architectural HI/LO registers. A mult/div result is computed at
// the accepting edge into pending registers {phi,plo}. A busy counter models
// the multi-cycle latency, and the pending result is committed to HI/LO when
// the counter reaches zero. The hazard unit stalls D-stage MDU instructions
// while busy is high.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (codes 9..12). When it is undefined, those codes behave as NONE.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   start      in   1   E-stage instruction is an MDU op (qualifies MDUOp)
//   MDUOp      in   4   operation code
//   req        in   1   exception/interrupt flush; suppresses the E-stage op
//   A, B       in   32  forwarded rs / rt operands
//   busy       out  1   mult/div in flight
//   HI, LO     out  32  architectural HI/LO
//   MDU_Result out  32  mfhi/mflo read value (0 for any other op)
// ---------------------------------------------------------------------------
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        nowrite_q, nowrite_d;
  logic        accept;

  // Products: operands are sign- or zero-extended to 64 bits so the low
  // 64 bits of the product are exact for both flavours.
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Division. Divide-by-zero and the single signed overflow case
  // (0x80000000 / -1) substitute a divisor of 1. For the overflow case this
  // naturally yields quotient 0x80000000 and remainder 0. For the zero case
  // the result is discarded through nowrite.
  logic               div_zero, div_ovf;
  logic signed [31:0] dvd_s, dvs_s, quot_s, rem_s;
  logic [31:0]        dvs_u, quot_u, rem_u;

  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign dvd_s    = $signed(A);
  assign dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
  assign quot_s   = dvd_s / dvs_s;
  assign rem_s    = dvd_s % dvs_s;
  assign dvs_u    = div_zero ? 32'd1 : B;
  assign quot_u   = A / dvs_u;
  assign rem_u    = A % dvs_u;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  assign busy   = (cnt_q != 4'd0);
  assign accept = start & ~req & ~busy;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    phi_d     = phi_q;
    plo_d     = plo_q;
    cnt_d     = cnt_q;
    nowrite_d = nowrite_q;

    // In-flight op: count down and commit at the 1 -> 0 edge. A flush
    // arriving now does not cancel it; the instruction is already past E.
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !nowrite_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end

    // accept implies not busy, so this never collides with a commit.
    if (accept) begin
      case (MDUOp)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
        OP_DIV: begin
          phi_d     = rem_s;
          plo_d     = quot_s;
          cnt_d     = 4'(DIV_CYCLES);
          nowrite_d = div_zero;
        end
        OP_DIVU: begin
          phi_d     = rem_u;
          plo_d     = quot_u;
          cnt_d     = 4'(DIV_CYCLES);
          nowrite_d = div_zero;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
        // Accumulate uses HI/LO as they stand at the accepting edge.
        OP_MADD: begin
          {phi_d, plo_d} = acc + prod_s;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
        OP_MADDU: begin
          {phi_d, plo_d} = acc + prod_u;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
        OP_MSUB: begin
          {phi_d, plo_d} = acc - prod_s;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
        OP_MSUBU: begin
          {phi_d, plo_d} = acc - prod_u;
          cnt_d          = 4'(MULT_CYCLES);
          nowrite_d      = 1'b0;
        end
`endif
        OP_NONE, OP_MFHI, OP_MFLO: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      phi_q     <= 32'd0;
      plo_q     <= 32'd0;
      cnt_q     <= 4'd0;
      nowrite_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      phi_q     <= phi_d;
      plo_q     <= plo_d;
      cnt_q     <= cnt_d;
      nowrite_q <= nowrite_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  always_comb begin
    MDU_Result = 32'd0;
    if (MDUOp == OP_MFHI)      MDU_Result = hi_q;
    else if (MDUOp == OP_MFLO) MDU_Result = lo_q;
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_ctrl -- directed self-checking bench for e_mdu_ctrl.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp;
  logic        req;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MDU_Result;

  int checks = 0;
  int passed = 0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .req(req),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDU_Result(MDU_Result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDUOp = op; A = a; B = b;
    step();
    start = 1'b0; MDUOp = 4'd0;
  endtask

  // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; MDUOp = 4'd5; req = 1'b0; A = 32'd0; B = 32'd0;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h expected 00000000", HI); else passed++;
    checks++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h expected 00000000", LO); else passed++;
    checks++; if (MDU_Result !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", MDU_Result); else passed++;
    reset = 1'b0; MDUOp = 4'd0;
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    checks++; if (LO !== 32'd0) $display("FAIL mult_no_early_commit: got %h expected 00000000", LO); else passed++;
    count_busy(n);
    checks++; if (n != 5) $display("FAIL mult_busy_cycles: got %0d expected 5", n); else passed++;
    checks++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", HI); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h expected fffffffa", LO); else passed++;
  endtask

  task automatic test_multu();
    int n;
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    checks++; if (n != 5) $display("FAIL multu_busy_cycles: got %0d expected 5", n); else passed++;
    checks++; if (HI !== 32'h0000_0002) $display("FAIL multu_hi: got %h expected 00000002", HI); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFA) $display("FAIL multu_lo: got %h expected fffffffa", LO); else passed++;
    MDUOp = 4'd5; #1;
    checks++; if (MDU_Result !== 32'h0000_0002) $display("FAIL mfhi_result: got %h expected 00000002", MDU_Result); else passed++;
    MDUOp = 4'd6; #1;
    checks++; if (MDU_Result !== 32'hFFFF_FFFA) $display("FAIL mflo_result: got %h expected fffffffa", MDU_Result); else passed++;
    MDUOp = 4'd0; #1;
    checks++; if (MDU_Result !== 32'd0) $display("FAIL none_result: got %h expected 00000000", MDU_Result); else passed++;
    step();
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++; if (n != 10) $display("FAIL div_busy_cycles: got %0d expected 10", n); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_quot: got %h expected fffffffd", LO); else passed++;
    checks++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_rem: got %h expected ffffffff", HI); else passed++;

    issue(4'd4, 32'd7, 32'd0);
    count_busy(n);
    checks++; if (n != 10) $display("FAIL divzero_busy_cycles: got %0d expected 10", n); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFD) $display("FAIL divzero_lo_kept: got %h expected fffffffd", LO); else passed++;
    checks++; if (HI !== 32'hFFFF_FFFF) $display("FAIL divzero_hi_kept: got %h expected ffffffff", HI); else passed++;

    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    count_busy(n);
    checks++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_negdivisor_quot: got %h expected fffffffd", LO); else passed++;
    checks++; if (HI !== 32'h0000_0001) $display("FAIL div_negdivisor_rem: got %h expected 00000001", HI); else passed++;

    issue(4'd4, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++; if (LO !== 32'h7FFF_FFFC) $display("FAIL divu_quot: got %h expected 7ffffffc", LO); else passed++;
    checks++; if (HI !== 32'h0000_0001) $display("FAIL divu_rem: got %h expected 00000001", HI); else passed++;

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++; if (LO !== 32'h8000_0000) $display("FAIL div_ovf_quot: got %h expected 80000000", LO); else passed++;
    checks++; if (HI !== 32'h0000_0000) $display("FAIL div_ovf_rem: got %h expected 00000000", HI); else passed++;
  endtask

  task automatic test_mt();
    start = 1'b1; req = 1'b1; MDUOp = 4'd8; A = 32'h1234_5678;
    step();
    start = 1'b0; req = 1'b0; MDUOp = 4'd0;
    checks++; if (LO !== 32'h8000_0000) $display("FAIL mtlo_flushed_lo: got %h expected 80000000", LO); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mtlo_flushed_busy: got %b expected 0", busy); else passed++;
    issue(4'd8, 32'h1234_5678, 32'd0);
    checks++; if (LO !== 32'h1234_5678) $display("FAIL mtlo_lo: got %h expected 12345678", LO); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b expected 0", busy); else passed++;
    MDUOp = 4'd6; #1;
    checks++; if (MDU_Result !== 32'h1234_5678) $display("FAIL mtlo_mflo: got %h expected 12345678", MDU_Result); else passed++;
    MDUOp = 4'd0;
    issue(4'd7, 32'hCAFE_F00D, 32'd0);
    checks++; if (HI !== 32'hCAFE_F00D) $display("FAIL mthi_hi: got %h expected cafef00d", HI); else passed++;
    checks++; if (LO !== 32'h1234_5678) $display("FAIL mthi_lo_kept: got %h expected 12345678", LO); else passed++;
  endtask

  task automatic test_reset_mid_op();
    issue(4'd1, 32'd5, 32'd7);
    step(); step();
    checks++; if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b expected 1", busy); else passed++;
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
    checks++; if (HI !== 32'd0) $display("FAIL midreset_hi: got %h expected 00000000", HI); else passed++;
    checks++; if (LO !== 32'd0) $display("FAIL midreset_lo: got %h expected 00000000", LO); else passed++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++; if (LO !== 32'd0) $display("FAIL midreset_no_commit_lo: got %h expected 00000000", LO); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_idle: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'd6, 32'd7);
    // Busy cycle 1: try to start an MTLO; must be ignored.
    start = 1'b1; MDUOp = 4'd8; A = 32'h0000_DEAD;
    step();
    // Busy cycle 2: try a DIV and raise a flush; in-flight mult must survive.
    MDUOp = 4'd3; A = 32'd100; B = 32'd3; req = 1'b1;
    step();
    start = 1'b0; MDUOp = 4'd0; req = 1'b0;
    count_busy(n);
    checks++; if (n != 3) $display("FAIL b2b_remaining_busy: got %0d expected 3", n); else passed++;
    checks++; if (LO !== 32'd42) $display("FAIL b2b_lo: got %h expected 0000002a", LO); else passed++;
    checks++; if (HI !== 32'd0) $display("FAIL b2b_hi: got %h expected 00000000", HI); else passed++;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL b2b_no_second_op: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_madd();
    int n;
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0);
    issue(4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    count_busy(n);
    checks++; if (n != 5) $display("FAIL maddu_busy_cycles: got %0d expected 5", n); else passed++;
    checks++; if (HI !== 32'd1) $display("FAIL maddu_hi: got %h expected 00000001", HI); else passed++;
    checks++; if (LO !== 32'd0) $display("FAIL maddu_lo: got %h expected 00000000", LO); else passed++;
    issue(4'd11, 32'd1, 32'd1);
    count_busy(n);
    checks++; if (HI !== 32'd0) $display("FAIL msub_hi: got %h expected 00000000", HI); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFF) $display("FAIL msub_lo: got %h expected ffffffff", LO); else passed++;
`else
    checks++; if (busy !== 1'b0) $display("FAIL maddu_off_busy: got %b expected 0", busy); else passed++;
    for (int i = 0; i < 6; i++) step();
    n = 0;
    checks++; if (HI !== 32'd0) $display("FAIL maddu_off_hi: got %h expected 00000000", HI); else passed++;
    checks++; if (LO !== 32'hFFFF_FFFF) $display("FAIL maddu_off_lo: got %h expected ffffffff", LO); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt();
    test_reset_mid_op();
    test_back_to_back();
    test_madd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multiply/divide unit and its sequencer in the E stage, alongside the ALU.
- Accepts an MDU operation from E, models the multi-cycle latency with a busy counter, and owns the HI/LO architectural registers.
- Provides the mfhi/mflo read result and a busy flag; the hazard unit uses busy to stall D-stage MDU instructions.
- Honours the exception/interrupt request so that a flushed E instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage instruction is an MDU op; qualifies MDUOp.
- MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9..12 see Optional Feature.
- req  input  1  exception/interrupt flush this cycle; suppresses the E-stage op.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  a mult/div operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDU_Result  output  32  MFHI gives HI, MFLO gives LO, any other op gives 0; combinational, valid without start.

Behaviour:
- Reset: HI=0, LO=0, cnt=0, busy=0, pending registers=0. Reset mid-operation aborts it with no commit.
- Accept condition: accept = start & ~req & ~busy. When start is high and either req or busy is high, the op is ignored and no state changes. The hazard unit guarantees start is never asserted while busy.
- MULT/MULTU: at the accepting edge, latch the 64-bit product into {phi,plo}; signed for MULT, unsigned for MULTU. Load cnt=MULT_CYCLES.
- DIV/DIVU: at the accepting edge, latch phi=remainder and plo=quotient; signed for DIV, unsigned for DIVU. Load cnt=DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divide by zero: busy still runs DIV_CYCLES cycles, but HI/LO are left unchanged at commit (internal nowrite flag).
- busy = (cnt != 0), taken from a register.
  - busy rises in the cycle after the accepting edge and stays high for exactly N cycles.
  - cnt decrements by 1 each edge while nonzero.
- Commit: at the edge where cnt goes 1 to 0, HI<=phi and LO<=plo, unless nowrite is set. The new values are visible in the first cycle with busy=0.
- MTHI/MTLO: on accept, HI<=A or LO<=A at that edge; no busy.
- MFHI/MFLO: no state change. MDU_Result reflects the current HI/LO, including a value committed at the previous edge.
- MDUOp NONE, and undefined codes: no effect.
- req arriving while busy does not cancel the in-flight operation; it commits normally, because the instruction was already past E.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Code 9 MADD: {HI,LO} += signed A*B.
  - Code 10 MADDU: {HI,LO} += unsigned A*B.
  - Code 11 MSUB: {HI,LO} -= signed A*B.
  - Code 12 MSUBU: {HI,LO} -= unsigned A*B.
  - The accumulate is computed at the accepting edge using HI/LO at that edge, with modulo 2^64 wrap.
  - Latency is MULT_CYCLES; commit follows the normal rules.
- Undefined: codes 9..12 behave as NONE.

Test Plan:
- MULT A=0xFFFFFFFE, B=3 -> busy high for 5 cycles starting the next cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFE, B=3 -> after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA. MFHI then gives MDU_Result=0x00000002.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with DIVU A=7, B=0 -> busy for 10 cycles, HI/LO unchanged.
- MTLO A=0x12345678 with start=1, req=1 -> LO unchanged, busy=0. Same op with req=0 -> LO=0x12345678 after one edge; MFLO gives 0x12345678.
- MULT accepted, then reset pulsed in busy cycle 3 -> busy=0, HI=LO=0 immediately and no later commit. Also start asserted while busy -> ignored, original result commits.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
